// File: rtl/simplez_pkg.sv
// Shared widths and state encoding for the
// two-port memory arbiter.
package simplez_pkg;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: on a tie the port
// that did not win last time is chosen.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       any,
  output logic       grant
);

  assign any   = |req;
  assign grant = (&req) ? ~last : ~req[0];

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port
// falling-edge memory: IDLE -> ACCESS -> ACK.
module mem_arbiter
  import simplez_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy,
  output logic              gnt
);

  state_t state;
  state_t state_nxt;
  logic   last;
  logic   arb_any;
  logic   arb_gnt;
  logic   start;

  rr_arb2 u_arb (
    .req   ({req1, req0}),
    .last  (last),
    .any   (arb_any),
    .grant (arb_gnt)
  );

  assign start = (state == IDLE) && arb_any;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (arb_any) state_nxt = ACCESS;
      ACCESS:  state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // last resets to 1 so port 0 wins the first tie
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gnt      <= 1'b0;
      last     <= 1'b1;
      mem_wr   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      rdata0   <= '0;
      rdata1   <= '0;
    end else begin
      if (start) begin
        gnt      <= arb_gnt;
        last     <= arb_gnt;
        mem_wr   <= arb_gnt ? we1 : we0;
        mem_addr <= arb_gnt ? addr1 : addr0;
        mem_din  <= arb_gnt ? wdata1 : wdata0;
      end
      if (state == ACCESS) begin
        mem_wr <= 1'b0;
        if (gnt) rdata1 <= mem_dout;
        else     rdata0 <= mem_dout;
      end
    end
  end

  assign busy = (state != IDLE);
  assign ack0 = (state == ACK) && !gnt;
  assign ack1 = (state == ACK) && gnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter
// with a falling-edge 512x12 memory model.
module tb_mem_arbiter;
  import simplez_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req0 = 0, we0 = 0;
  logic        req1 = 0, we1 = 0;
  logic [8:0]  addr0 = 0, addr1 = 0;
  logic [11:0] wdata0 = 0, wdata1 = 0;
  logic        ack0, ack1, busy, gnt;
  logic [11:0] rdata0, rdata1;
  logic [8:0]  mem_addr;
  logic        mem_wr;
  logic [11:0] mem_din;
  logic [11:0] mem_dout = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rstn(rstn),
    .req0(req0), .we0(we0), .addr0(addr0),
    .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1),
    .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wr(mem_wr),
    .mem_din(mem_din), .mem_dout(mem_dout),
    .busy(busy), .gnt(gnt)
  );

  logic [11:0] mem [512];
  logic [11:0] ref_mem [512];

  // read-before-write memory, active on falling edge
  always @(negedge clk) begin
    mem_dout = mem[mem_addr];
    if (mem_wr) mem[mem_addr] = mem_din;
  end

  typedef struct {
    logic        we;
    logic [8:0]  addr;
    logic [11:0] wdata;
  } tr_t;

  typedef struct {
    logic        port;
    logic [11:0] rdata;
    int          cyc;
  } exp_t;

  tr_t  pq0[$];
  tr_t  pq1[$];
  exp_t sbq[$];
  logic lastg = 1'b1;
  int   cyc = 0;
  int   wrcnt = 0;
  int   checks = 0;
  int   fails = 0;
  logic [11:0] exp_rd0 = 0, exp_rd1 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%0h exp=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // monitor: pops expectations whenever an ack shows
  always @(negedge clk) begin
    exp_t e;
    if (!rstn) begin
      exp_rd0 = 0;
      exp_rd1 = 0;
    end else begin
      if (mem_wr) wrcnt++;
      if (ack0 || ack1) begin
        if (sbq.size() == 0) begin
          chk("unexpected_ack", {ack1, ack0}, 0);
        end else begin
          e = sbq.pop_front();
          chk("ack_vec", {ack1, ack0},
              e.port ? 2'b10 : 2'b01);
          chk("ack_gnt", gnt, e.port);
          chk("ack_busy", busy, 1);
          chk("ack_cycle", cyc, e.cyc);
          if (e.port) exp_rd1 = e.rdata;
          else        exp_rd0 = e.rdata;
        end
      end
      chk("rdata0", rdata0, exp_rd0);
      chk("rdata1", rdata1, exp_rd1);
    end
  end

  int nw;

  // reference: order by round robin, one slot per 3 cycles
  task automatic plan_round(input int c0);
    int   i0 = 0, i1 = 0, k = 0;
    logic p;
    tr_t  t;
    exp_t e;
    nw = 0;
    while (i0 < pq0.size() || i1 < pq1.size()) begin
      if (i0 < pq0.size() && i1 < pq1.size())
        p = ~lastg;
      else
        p = (i0 < pq0.size()) ? 1'b0 : 1'b1;
      if (p) begin t = pq1[i1]; i1++; end
      else   begin t = pq0[i0]; i0++; end
      e.port  = p;
      e.rdata = ref_mem[t.addr];
      e.cyc   = c0 + 2 + 3 * k;
      if (t.we) begin
        ref_mem[t.addr] = t.wdata;
        nw++;
      end
      lastg = p;
      sbq.push_back(e);
      k++;
    end
  endtask

  task automatic drive(input bit p);
    tr_t q[$];
    bit  got;
    q = p ? pq1 : pq0;
    foreach (q[i]) begin
      if (p) begin
        we1 = q[i].we; addr1 = q[i].addr;
        wdata1 = q[i].wdata; req1 = 1;
      end else begin
        we0 = q[i].we; addr0 = q[i].addr;
        wdata0 = q[i].wdata; req0 = 1;
      end
      got = 0;
      for (int t = 0; t < 40; t++) begin
        @(negedge clk);
        if ((p ? ack1 : ack0) === 1'b1) begin
          got = 1;
          break;
        end
      end
      if (!got) begin
        checks++;
        fails++;
        $display("FAIL ack_timeout port=%0d act=0 exp=1",
                 p);
      end
      @(posedge clk); #1;
    end
    if (p) req1 = 0;
    else   req0 = 0;
  endtask

  task automatic run_round();
    int w0;
    @(posedge clk); #1;
    w0 = wrcnt;
    plan_round(cyc);
    fork
      drive(1'b0);
      drive(1'b1);
    join
    chk("wr_pulses", wrcnt - w0, nw);
    chk("sb_drained", sbq.size(), 0);
    pq0.delete();
    pq1.delete();
  endtask

  function automatic tr_t mk(input logic we,
                             input logic [8:0] a,
                             input logic [11:0] d);
    tr_t t;
    t.we = we; t.addr = a; t.wdata = d;
    return t;
  endfunction

  task automatic chk_zero(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_gnt"}, gnt, 0);
    chk({nm, "_acks"}, {ack1, ack0}, 0);
    chk({nm, "_wr"}, mem_wr, 0);
    chk({nm, "_addr"}, mem_addr, 0);
    chk({nm, "_din"}, mem_din, 0);
    chk({nm, "_rd0"}, rdata0, 0);
    chk({nm, "_rd1"}, rdata1, 0);
  endtask

  initial begin
    for (int i = 0; i < 512; i++)
      mem[i] = 12'($urandom);
    mem[8] = 12'o0001;
    mem[5] = 12'o0005;
    for (int i = 0; i < 512; i++)
      ref_mem[i] = mem[i];

    repeat (3) @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1 rstn = 1;

    // single read on port 0
    pq0.push_back(mk(0, 9'd8, 12'd0));
    run_round();

    // port 1 write then read at top address
    pq1.push_back(mk(1, 9'o777, 12'o1234));
    pq1.push_back(mk(0, 9'o777, 12'd0));
    run_round();

    // reset while in ACCESS aborts the write
    @(posedge clk); #1;
    we0 = 1; addr0 = 9'd5;
    wdata0 = 12'o7777; req0 = 1;
    @(posedge clk); #1;
    chk("access_busy", busy, 1);
    chk("access_wr", mem_wr, 1);
    rstn = 0;
    #1 chk_zero("abort");
    req0 = 0;
    lastg = 1;
    repeat (3) begin
      @(negedge clk);
      chk("abort_noack", {ack1, ack0}, 0);
    end
    chk("abort_mem5", mem[5], 12'o0005);
    @(posedge clk); #1 rstn = 1;

    // reset with both requests high
    @(posedge clk); #1;
    rstn = 0;
    req0 = 1; req1 = 1;
    @(negedge clk);
    chk("rst_req_busy", busy, 0);
    chk("rst_req_acks", {ack1, ack0}, 0);
    @(posedge clk); #1;
    req0 = 0; req1 = 0;
    lastg = 1;
    rstn = 1;

    // tie after reset: expect 0,1,0,1
    pq0.push_back(mk(0, 9'd8, 12'd0));
    pq0.push_back(mk(1, 9'd40, 12'o4321));
    pq1.push_back(mk(0, 9'd5, 12'd0));
    pq1.push_back(mk(0, 9'd40, 12'd0));
    run_round();

    // back-to-back single requester
    for (int i = 0; i < 4; i++)
      pq0.push_back(mk(1'($urandom), 9'($urandom),
                       12'($urandom)));
    run_round();

    for (int r = 0; r < 40; r++) begin
      int n0, n1;
      n0 = $urandom_range(0, 3);
      n1 = $urandom_range(0, 3);
      for (int i = 0; i < n0; i++)
        pq0.push_back(mk(1'($urandom),
                         9'($urandom_range(0, 15)),
                         12'($urandom)));
      for (int i = 0; i < n1; i++)
        pq1.push_back(mk(1'($urandom),
                         9'($urandom_range(0, 15)),
                         12'($urandom)));
      run_round();
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule
